// File: rtl/video_pkg.sv
// Shared types and constants for the video pattern scheduler.
package video_pkg;

    typedef enum logic [1:0] {
        SCH_RUN     = 2'd0,
        SCH_PENDING = 2'd1,
        SCH_BLANK   = 2'd2
    } sched_state_t;

    localparam logic DIR_NEXT = 1'b0;
    localparam logic DIR_PREV = 1'b1;

endpackage

// File: rtl/video_frame_counter.sv
// Saturating frame counter; clr has priority over inc.
module video_frame_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/video_pattern_scheduler.sv
// Frame-aligned test-pattern sequencer for VIDEO_source (manual next/prev plus auto-advance).
// Optional PATTERN_BLANK_EN inserts one black frame between patterns.
module video_pattern_scheduler
    import video_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS = 8,
    parameter int unsigned PATW         = 3,
    parameter int unsigned HOLD_FRAMES  = 120,
    parameter int unsigned FCNTW        = 16
) (
    input  logic             video_clk_pix,
    input  logic             video_rst_n,
    input  logic             frame_start,
    input  logic             auto_en,
    input  logic             req_valid,
    input  logic             req_dir,
    output logic             req_ready,
    output logic [PATW-1:0]  pattern_id,
    output logic             pattern_changed,
    output logic [FCNTW-1:0] frame_count,
    output logic             blank
);

    localparam logic [PATW-1:0]  LAST_ID   = PATW'(NUM_PATTERNS - 1);
    localparam logic [FCNTW-1:0] HOLD_LAST = FCNTW'(HOLD_FRAMES - 1);

    sched_state_t    state_q, state_d;
    logic            pend_dir_q, pend_dir_d;
    logic [PATW-1:0] pattern_id_q, pattern_id_d;
    logic            pattern_changed_q, pattern_changed_d;
    logic            req_ready_q, req_ready_d;
    logic [PATW-1:0] step_id;
    logic            accept;
    logic            auto_hit;
    logic            fc_inc;
    logic            fc_clr;
`ifdef PATTERN_BLANK_EN
    logic            blank_q, blank_d;
`endif

    assign accept   = req_valid & req_ready_q;
    assign auto_hit = frame_start & auto_en & (frame_count == HOLD_LAST);

    // Wrap-around neighbour of the current pattern in the latched direction.
    always_comb begin
        if (pend_dir_q == DIR_NEXT) begin
            step_id = (pattern_id_q == LAST_ID) ? '0 : pattern_id_q + PATW'(1);
        end else begin
            step_id = (pattern_id_q == '0) ? LAST_ID : pattern_id_q - PATW'(1);
        end
    end

    always_comb begin
        state_d           = state_q;
        pend_dir_d        = pend_dir_q;
        pattern_id_d      = pattern_id_q;
        pattern_changed_d = 1'b0;
        fc_inc            = frame_start;
        fc_clr            = 1'b0;
`ifdef PATTERN_BLANK_EN
        blank_d           = blank_q;
`endif
        unique case (state_q)
            SCH_RUN: begin
                // Manual request beats the auto trigger in the same cycle.
                if (accept) begin
                    pend_dir_d = req_dir;
                    state_d    = SCH_PENDING;
                end else if (auto_hit) begin
                    pend_dir_d = DIR_NEXT;
                    state_d    = SCH_PENDING;
                end
            end
            SCH_PENDING: begin
                if (frame_start) begin
`ifdef PATTERN_BLANK_EN
                    blank_d = 1'b1;
                    state_d = SCH_BLANK;
`else
                    pattern_id_d      = step_id;
                    pattern_changed_d = 1'b1;
                    fc_clr            = 1'b1;
                    state_d           = SCH_RUN;
`endif
                end
            end
`ifdef PATTERN_BLANK_EN
            SCH_BLANK: begin
                if (frame_start) begin
                    pattern_id_d      = step_id;
                    pattern_changed_d = 1'b1;
                    fc_clr            = 1'b1;
                    blank_d           = 1'b0;
                    state_d           = SCH_RUN;
                end
            end
`endif
            default: begin
                state_d = SCH_RUN;
            end
        endcase
        req_ready_d = (state_d == SCH_RUN);
    end

    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            state_q           <= SCH_RUN;
            pend_dir_q        <= DIR_NEXT;
            pattern_id_q      <= '0;
            pattern_changed_q <= 1'b0;
            req_ready_q       <= 1'b1;
        end else begin
            state_q           <= state_d;
            pend_dir_q        <= pend_dir_d;
            pattern_id_q      <= pattern_id_d;
            pattern_changed_q <= pattern_changed_d;
            req_ready_q       <= req_ready_d;
        end
    end

`ifdef PATTERN_BLANK_EN
    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

    video_frame_counter #(
        .W(FCNTW)
    ) u_frame_counter (
        .clk   (video_clk_pix),
        .rst_n (video_rst_n),
        .inc   (fc_inc),
        .clr   (fc_clr),
        .count (frame_count)
    );

    assign req_ready       = req_ready_q;
    assign pattern_id      = pattern_id_q;
    assign pattern_changed = pattern_changed_q;

endmodule

// File: tb/tb_video_pattern_scheduler.sv
// Directed self-checking bench for video_pattern_scheduler (HOLD_FRAMES=4, FCNTW=3).
module tb_video_pattern_scheduler;

    localparam int unsigned NUM_PATTERNS = 8;
    localparam int unsigned PATW         = 3;
    localparam int unsigned HOLD_FRAMES  = 4;
    localparam int unsigned FCNTW        = 3;

    logic             clk;
    logic             rst_n;
    logic             frame_start;
    logic             auto_en;
    logic             req_valid;
    logic             req_dir;
    logic             req_ready;
    logic [PATW-1:0]  pattern_id;
    logic             pattern_changed;
    logic [FCNTW-1:0] frame_count;
    logic             blank;

    int checks;
    int errors;

    video_pattern_scheduler #(
        .NUM_PATTERNS (NUM_PATTERNS),
        .PATW         (PATW),
        .HOLD_FRAMES  (HOLD_FRAMES),
        .FCNTW        (FCNTW)
    ) dut (
        .video_clk_pix   (clk),
        .video_rst_n     (rst_n),
        .frame_start     (frame_start),
        .auto_en         (auto_en),
        .req_valid       (req_valid),
        .req_dir         (req_dir),
        .req_ready       (req_ready),
        .pattern_id      (pattern_id),
        .pattern_changed (pattern_changed),
        .frame_count     (frame_count),
        .blank           (blank)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic request(input logic dir);
        req_valid = 1'b1;
        req_dir   = dir;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic commit_frames();
`ifdef PATTERN_BLANK_EN
        frame();
        idle(1);
`endif
        frame();
    endtask

    task automatic step(input logic dir);
        request(dir);
        idle(1);
        commit_frames();
        idle(1);
    endtask

    task automatic do_reset();
        frame_start = 1'b0;
        auto_en     = 1'b0;
        req_valid   = 1'b0;
        req_dir     = 1'b0;
        rst_n       = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pattern_id !== 3'd0) begin $display("FAIL reset_pattern: got %0d expected 0", pattern_id); errors++; end
        checks++; if (req_ready !== 1'b1) begin $display("FAIL reset_ready: got %0b expected 1", req_ready); errors++; end
        step(1'b0);
        frame();
        request(1'b0);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pattern_id !== 3'd0) begin $display("FAIL midreset_pattern: got %0d expected 0", pattern_id); errors++; end
        checks++; if (blank !== 1'b0) begin $display("FAIL midreset_blank: got %0b expected 0", blank); errors++; end
        checks++; if (req_ready !== 1'b1) begin $display("FAIL midreset_ready: got %0b expected 1", req_ready); errors++; end
        checks++; if (frame_count !== 3'd0) begin $display("FAIL midreset_fc: got %0d expected 0", frame_count); errors++; end
        checks++; if (pattern_changed !== 1'b0) begin $display("FAIL midreset_changed: got %0b expected 0", pattern_changed); errors++; end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        frame();
        checks++; if (pattern_id !== 3'd0) begin $display("FAIL postreset_discard: got %0d expected 0", pattern_id); errors++; end
        checks++; if (frame_count !== 3'd1) begin $display("FAIL postreset_fc: got %0d expected 1", frame_count); errors++; end
    endtask

    task automatic test_manual_next();
        do_reset();
        step(1'b0);
        step(1'b0);
        step(1'b0);
        checks++; if (pattern_id !== 3'd3) begin $display("FAIL setup_pattern3: got %0d expected 3", pattern_id); errors++; end
        request(1'b0);
        checks++; if (req_ready !== 1'b0) begin $display("FAIL next_ready_low: got %0b expected 0", req_ready); errors++; end
        idle(3);
        checks++; if (req_ready !== 1'b0) begin $display("FAIL next_ready_held: got %0b expected 0", req_ready); errors++; end
        checks++; if (pattern_id !== 3'd3) begin $display("FAIL next_early: got %0d expected 3", pattern_id); errors++; end
`ifdef PATTERN_BLANK_EN
        frame();
        checks++; if (blank !== 1'b1) begin $display("FAIL blank_on: got %0b expected 1", blank); errors++; end
        checks++; if (pattern_id !== 3'd3) begin $display("FAIL blank_pattern: got %0d expected 3", pattern_id); errors++; end
        checks++; if (req_ready !== 1'b0) begin $display("FAIL blank_ready: got %0b expected 0", req_ready); errors++; end
        idle(3);
        checks++; if (blank !== 1'b1) begin $display("FAIL blank_hold: got %0b expected 1", blank); errors++; end
`endif
        frame();
        checks++; if (pattern_id !== 3'd4) begin $display("FAIL next_commit: got %0d expected 4", pattern_id); errors++; end
        checks++; if (pattern_changed !== 1'b1) begin $display("FAIL next_pulse: got %0b expected 1", pattern_changed); errors++; end
        checks++; if (frame_count !== 3'd0) begin $display("FAIL next_fc_clr: got %0d expected 0", frame_count); errors++; end
        checks++; if (req_ready !== 1'b1) begin $display("FAIL next_ready_back: got %0b expected 1", req_ready); errors++; end
        checks++; if (blank !== 1'b0) begin $display("FAIL next_blank_off: got %0b expected 0", blank); errors++; end
        idle(1);
        checks++; if (pattern_changed !== 1'b0) begin $display("FAIL next_pulse_width: got %0b expected 0", pattern_changed); errors++; end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b1);
        checks++; if (pattern_id !== 3'd7) begin $display("FAIL wrap_prev: got %0d expected 7", pattern_id); errors++; end
        step(1'b0);
        checks++; if (pattern_id !== 3'd0) begin $display("FAIL wrap_next: got %0d expected 0", pattern_id); errors++; end
    endtask

    task automatic test_auto();
`ifdef PATTERN_BLANK_EN
        logic [2:0] exp_fc  [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [2:0] exp_pat [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        logic       exp_chg [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       exp_blk [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        logic [2:0] exp_fc  [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        logic [2:0] exp_pat [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
        logic       exp_chg [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_blk [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        auto_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idle(2);
            frame();
            checks++; if (frame_count !== exp_fc[i]) begin $display("FAIL auto_fc[%0d]: got %0d expected %0d", i, frame_count, exp_fc[i]); errors++; end
            checks++; if (pattern_id !== exp_pat[i]) begin $display("FAIL auto_pattern[%0d]: got %0d expected %0d", i, pattern_id, exp_pat[i]); errors++; end
            checks++; if (pattern_changed !== exp_chg[i]) begin $display("FAIL auto_changed[%0d]: got %0b expected %0b", i, pattern_changed, exp_chg[i]); errors++; end
            checks++; if (blank !== exp_blk[i]) begin $display("FAIL auto_blank[%0d]: got %0b expected %0b", i, blank, exp_blk[i]); errors++; end
        end
        auto_en = 1'b0;
    endtask

    task automatic test_collision();
        do_reset();
        step(1'b0);
        step(1'b0);
        repeat (3) begin
            frame();
            idle(1);
        end
        checks++; if (frame_count !== 3'd3) begin $display("FAIL coll_fc_setup: got %0d expected 3", frame_count); errors++; end
        checks++; if (pattern_id !== 3'd2) begin $display("FAIL coll_pattern_setup: got %0d expected 2", pattern_id); errors++; end
        auto_en     = 1'b1;
        req_valid   = 1'b1;
        req_dir     = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        req_valid   = 1'b0;
        frame_start = 1'b0;
        auto_en     = 1'b0;
        checks++; if (pattern_id !== 3'd2) begin $display("FAIL coll_no_same_frame: got %0d expected 2", pattern_id); errors++; end
        checks++; if (req_ready !== 1'b0) begin $display("FAIL coll_ready: got %0b expected 0", req_ready); errors++; end
        checks++; if (frame_count !== 3'd4) begin $display("FAIL coll_fc: got %0d expected 4", frame_count); errors++; end
        idle(2);
        commit_frames();
        checks++; if (pattern_id !== 3'd1) begin $display("FAIL coll_manual_wins: got %0d expected 1", pattern_id); errors++; end
    endtask

    task automatic test_back_to_back();
        do_reset();
        request(1'b0);
        req_valid = 1'b1;
        req_dir   = 1'b1;
        idle(2);
        checks++; if (req_ready !== 1'b0) begin $display("FAIL b2b_stall: got %0b expected 0", req_ready); errors++; end
        commit_frames();
        checks++; if (pattern_id !== 3'd1) begin $display("FAIL b2b_first: got %0d expected 1", pattern_id); errors++; end
        checks++; if (req_ready !== 1'b1) begin $display("FAIL b2b_ready_back: got %0b expected 1", req_ready); errors++; end
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin $display("FAIL b2b_stalled_accept: got %0b expected 0", req_ready); errors++; end
        idle(1);
        commit_frames();
        checks++; if (pattern_id !== 3'd0) begin $display("FAIL b2b_second: got %0d expected 0", pattern_id); errors++; end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (9) begin
            frame();
            idle(1);
        end
        checks++; if (frame_count !== 3'd7) begin $display("FAIL sat_fc: got %0d expected 7", frame_count); errors++; end
        checks++; if (pattern_id !== 3'd0) begin $display("FAIL sat_pattern: got %0d expected 0", pattern_id); errors++; end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        auto_en     = 1'b0;
        req_valid   = 1'b0;
        req_dir     = 1'b0;
        test_reset();
        test_manual_next();
        test_wrap();
        test_auto();
        test_collision();
        test_back_to_back();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
